// File: rtl/seq_detect_pkg.sv
// Shared types, default sizes and helpers for the seq_detect_ctrl run controller.
package seq_detect_pkg;

  localparam int unsigned DEFAULT_MAX_LEN = 8;
  localparam int unsigned DEFAULT_LEN_W   = 4;
  localparam int unsigned DEFAULT_CNT_W   = 8;
  localparam int unsigned DEFAULT_TMO_W   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDone
  } state_e;

  // Length 0 behaves as 1; anything beyond the window size is cut to the window size.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_detect_if.sv
// Valid/ready stream of 2-bit symbols feeding the sequence detector.
interface seq_detect_if;

  logic       data_valid;
  logic [1:0] data;
  logic       data_ready;

  modport master (output data_valid, output data, input data_ready);
  modport slave  (input data_valid, input data, output data_ready);

endinterface

// File: rtl/seq_hist_window.sv
// Symbol history, fill counter and length-masked pattern compare for the incoming beat.
// SEQ_DETECT_NON_OVERLAP_EN: clear the fill count on a hit so matches cannot share symbols.
module seq_hist_window
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
  parameter int unsigned LEN_W   = DEFAULT_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en,
  input  logic                 clear,
  input  logic [1:0]           sym,
  input  logic [2*MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]     len,
  output logic                 match
);

  localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);

  logic [2*MAX_LEN-1:0] hist_q, hist_next;
  logic [FILL_W-1:0]    fill_q, fill_inc;
  logic                 window_eq;

  // Match is evaluated on the history as it will look once this beat is shifted in.
  always_comb begin
    hist_next      = hist_q << 2;
    hist_next[1:0] = sym;
    fill_inc       = (fill_q == FILL_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    window_eq      = 1'b1;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len)) begin
        if (hist_next[2*(32'(len)-1-i) +: 2] != pattern[2*i +: 2]) window_eq = 1'b0;
      end
    end
    match = shift_en && (32'(fill_inc) >= 32'(len)) && window_eq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_next;
`ifdef SEQ_DETECT_NON_OVERLAP_EN
      fill_q <= match ? '0 : fill_inc;
`else
      fill_q <= fill_inc;
`endif
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Start/stop sequenced run controller for programmable 2-bit-symbol pattern detection.
// SEQ_DETECT_NON_OVERLAP_EN selects non-overlapping matching inside seq_hist_window.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
  parameter int unsigned LEN_W   = DEFAULT_LEN_W,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W,
  parameter int unsigned TMO_W   = DEFAULT_TMO_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [2*MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [CNT_W-1:0]     cfg_hit_target,
  input  logic [TMO_W-1:0]     cfg_timeout,
  input  logic                 start,
  input  logic                 abort,
  seq_detect_if.slave          in_if,
  output logic                 busy,
  output logic                 success,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [TMO_W-1:0]     sym_cnt
);

  state_e               state_q, state_d;
  logic [2*MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]     len_q;
  logic [CNT_W-1:0]     target_q, hit_q, hit_d, hit_inc;
  logic [TMO_W-1:0]     tmo_lim_q, sym_q, sym_d, sym_inc;
  logic                 success_q, success_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic                 accept, shift_en, win_clear, match;

  assign in_if.data_ready = (state_q == StRun);
  assign busy             = (state_q == StArm) || (state_q == StRun);
  assign done             = (state_q == StDone);
  assign timeout          = done && tmo_flag_q;
  assign success          = success_q;
  assign hit_cnt          = hit_q;
  assign sym_cnt          = sym_q;

  assign accept   = (state_q == StRun) && in_if.data_valid;
  assign shift_en = accept && !abort;

  seq_hist_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clear    (win_clear),
    .sym      (in_if.data),
    .pattern  (pattern_q),
    .len      (len_q),
    .match    (match)
  );

  always_comb begin
    state_d    = state_q;
    hit_d      = hit_q;
    sym_d      = sym_q;
    success_d  = 1'b0;
    tmo_flag_d = tmo_flag_q;
    win_clear  = 1'b0;
    hit_inc    = (&hit_q) ? hit_q : hit_q + 1'b1;
    sym_inc    = sym_q + 1'b1;
    unique case (state_q)
      StIdle, StDone: begin
        if (abort)      state_d = StIdle;
        else if (start) state_d = StArm;
      end
      StArm: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d    = StRun;
          hit_d      = '0;
          sym_d      = '0;
          tmo_flag_d = 1'b0;
          win_clear  = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (accept) begin
          sym_d = sym_inc;
          if (match) begin
            hit_d     = hit_inc;
            success_d = 1'b1;
          end
          // A hit reaching the target takes precedence over a simultaneous timeout.
          if ((target_q != '0) && match && (hit_inc == target_q)) begin
            state_d    = StDone;
            tmo_flag_d = 1'b0;
          end else if ((tmo_lim_q != '0) && (sym_inc == tmo_lim_q)) begin
            state_d    = StDone;
            tmo_flag_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hit_q      <= '0;
      sym_q      <= '0;
      success_q  <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hit_q      <= hit_d;
      sym_q      <= sym_d;
      success_q  <= success_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      len_q     <= LEN_W'(1);
      target_q  <= '0;
      tmo_lim_q <= '0;
    end else if (cfg_we && !busy) begin
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      target_q  <= cfg_hit_target;
      tmo_lim_q <= cfg_timeout;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl; honours SEQ_DETECT_NON_OVERLAP_EN.
module tb_seq_detect_ctrl;

`ifdef SEQ_DETECT_NON_OVERLAP_EN
  localparam bit NON_OV = 1'b1;
`else
  localparam bit NON_OV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic [7:0]  cfg_hit_target = '0;
  logic [15:0] cfg_timeout = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, success, done, timeout;
  logic [7:0]  hit_cnt;
  logic [15:0] sym_cnt;

  int checks = 0;
  int failures = 0;

  seq_detect_if sif ();

  seq_detect_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_pattern    (cfg_pattern),
    .cfg_len        (cfg_len),
    .cfg_hit_target (cfg_hit_target),
    .cfg_timeout    (cfg_timeout),
    .start          (start),
    .abort          (abort),
    .in_if          (sif),
    .busy           (busy),
    .success        (success),
    .done           (done),
    .timeout        (timeout),
    .hit_cnt        (hit_cnt),
    .sym_cnt        (sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [15:0] pat, input logic [3:0] len,
                           input logic [7:0] tgt, input logic [15:0] tmo);
    cfg_pattern = pat;
    cfg_len = len;
    cfg_hit_target = tgt;
    cfg_timeout = tmo;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Leaves the DUT in RUN (start -> ARM -> RUN).
  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic beat(input logic [1:0] sym);
    sif.data_valid = 1'b1;
    sif.data = sym;
    tick();
    sif.data_valid = 1'b0;
  endtask

  initial begin
    sif.data_valid = 1'b0;
    sif.data = 2'd0;
    #22 rst_n = 1'b1;
    tick();

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", sif.data_ready, 0);
    check("rst_success", success, 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_sym", sym_cnt, 0);
    check("rst_timeout", timeout, 0);

    // Overlapping detection of 0,1,0 in 0,1,0,1,0.
    configure(16'h0004, 4'd3, 8'd0, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_ready", sif.data_ready, 0);
    tick();
    check("run_ready", sif.data_ready, 1);
    beat(2'd0);
    beat(2'd1);
    check("p1_b2_success", success, 0);
    beat(2'd0);
    check("p1_b3_success", success, 1);
    check("p1_b3_hit", hit_cnt, 1);
    beat(2'd1);
    check("p1_b4_success", success, 0);
    beat(2'd0);
    check("p1_b5_success", success, NON_OV ? 0 : 1);
    check("p1_b5_hit", hit_cnt, NON_OV ? 1 : 2);
    check("p1_b5_sym", sym_cnt, 5);
    tick();
    check("p1_pulse_len", success, 0);
    check("p1_not_done", done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("p1_abort_idle", busy, 0);
    check("p1_abort_hit_kept", hit_cnt, NON_OV ? 1 : 2);

    // Hit target 2 with pattern 3,3 on stream 3,3,3,3.
    configure(16'h000F, 4'd2, 8'd2, 16'd0);
    run_start();
    beat(2'd3);
    beat(2'd3);
    check("p2_b2_success", success, 1);
    beat(2'd3);
    check("p2_b3_done", done, NON_OV ? 0 : 1);
    check("p2_b3_ready", sif.data_ready, NON_OV ? 1 : 0);
    check("p2_b3_hit", hit_cnt, NON_OV ? 1 : 2);
    beat(2'd3);
    check("p2_b4_sym", sym_cnt, NON_OV ? 4 : 3);
    check("p2_b4_done", done, 1);
    check("p2_b4_hit", hit_cnt, 2);
    check("p2_b4_timeout", timeout, 0);

    // Timeout after 4 beats, pattern never present.
    configure(16'h000F, 4'd2, 8'd0, 16'd4);
    run_start();
    beat(2'd0);
    beat(2'd1);
    beat(2'd2);
    check("p3_b3_done", done, 0);
    beat(2'd0);
    check("p3_done", done, 1);
    check("p3_timeout", timeout, 1);
    check("p3_sym", sym_cnt, 4);
    check("p3_hit", hit_cnt, 0);

    // cfg_we with start from DONE: len 1, pattern 2, target 1; hit on beat 4 beats timeout.
    cfg_pattern = 16'h0002;
    cfg_len = 4'd1;
    cfg_hit_target = 8'd1;
    cfg_timeout = 16'd4;
    cfg_we = 1'b1;
    start = 1'b1;
    tick();
    cfg_we = 1'b0;
    start = 1'b0;
    check("p4_arm_done_clr", done, 0);
    tick();
    beat(2'd0);
    beat(2'd1);
    beat(2'd0);
    beat(2'd2);
    check("p4_done", done, 1);
    check("p4_timeout", timeout, 0);
    check("p4_success", success, 1);
    check("p4_hit", hit_cnt, 1);

    // Start with abort from DONE goes to IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("p5_sa_busy", busy, 0);
    check("p5_sa_done", done, 0);

    // Abort on a would-be matching beat.
    configure(16'h0004, 4'd3, 8'd0, 16'd0);
    run_start();
    beat(2'd0);
    beat(2'd1);
    abort = 1'b1;
    beat(2'd0);
    abort = 1'b0;
    check("p5_ab_busy", busy, 0);
    check("p5_ab_success", success, 0);
    check("p5_ab_done", done, 0);
    check("p5_ab_hit", hit_cnt, 0);
    check("p5_ab_sym", sym_cnt, 2);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("p5_idle_sa_busy", busy, 0);

    // len 0 clamps to 1; cfg_we during RUN is ignored.
    configure(16'h0001, 4'd0, 8'd0, 16'd0);
    run_start();
    configure(16'h0002, 4'd1, 8'd1, 16'd1);
    beat(2'd1);
    check("p6_b1_success", success, 1);
    beat(2'd2);
    check("p6_b2_success", success, 0);
    check("p6_b2_done", done, 0);
    beat(2'd1);
    check("p6_b3_success", success, 1);
    check("p6_b3_hit", hit_cnt, 2);
    check("p6_b3_sym", sym_cnt, 3);

    // Reset mid-run right after a hit.
    beat(2'd1);
    rst_n = 1'b0;
    #1;
    check("p7_rst_success", success, 0);
    check("p7_rst_busy", busy, 0);
    check("p7_rst_hit", hit_cnt, 0);
    check("p7_rst_sym", sym_cnt, 0);
    check("p7_rst_ready", sif.data_ready, 0);
    #10 rst_n = 1'b1;
    tick();
    check("p7_post_success", success, 0);
    check("p7_post_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run controller for 2-bit-symbol sequence detection: holds a programmable target pattern and accepts a valid/ready symbol stream.
- Counts pattern hits, overlapping by default, and ends a run on a hit target or a symbol timeout.
- Sits between the stimulus/data source and downstream logic.
- Replaces fixed-pattern detection with a configurable, start/stop-sequenced engine.

Parameters:
- MAX_LEN, 8, maximum pattern length in 2-bit symbols.
- LEN_W, 4, width of cfg_len; must hold MAX_LEN.
- CNT_W, 8, width of the hit counter and hit target.
- TMO_W, 16, width of the symbol counter and timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  load cfg_* into shadow registers; ignored while busy=1.
- cfg_pattern  in  2*MAX_LEN  pattern; symbol 0 (oldest) is in bits [1:0].
- cfg_len  in  LEN_W  pattern length; 0 is clamped to 1, values >MAX_LEN are clamped to MAX_LEN.
- cfg_hit_target  in  CNT_W  number of hits that ends a run; 0 means unlimited.
- cfg_timeout  in  TMO_W  maximum accepted symbols per run; 0 means no timeout.
- start  in  1  begin a run; accepted in IDLE or DONE.
- abort  in  1  terminate the current run.
- data_valid  in  1  symbol valid.
- data  in  2  symbol.
- data_ready  out  1  symbol accepted when data_valid&&data_ready.
- busy  out  1  state is ARM or RUN.
- success  out  1  one-cycle pulse per hit.
- done  out  1  level, high in DONE.
- timeout  out  1  level, high in DONE when the run ended by timeout.
- hit_cnt  out  CNT_W  hits in the current or last run; saturates at all-ones.
- sym_cnt  out  TMO_W  symbols accepted in the current or last run.

Behaviour:
- Reset values: state IDLE; all outputs 0; shadow cfg = pattern 0, len 1, target 0, timeout 0; history cleared.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE/DONE + start → ARM.
  - ARM lasts one cycle: clears history, fill count, hit_cnt, sym_cnt, done, timeout.
  - ARM → RUN.
- data_ready = (state==RUN).
- Each accepted beat:
  - history shifts left by 2 with the new symbol in bits [1:0].
  - fill count increments, saturating at MAX_LEN.
  - sym_cnt increments.
- Match condition on an accepted beat: fill count (including this beat) ≥ len, and the last len symbols equal the pattern in order (oldest to newest).
- success is registered: it pulses the cycle after the matching beat. hit_cnt updates in the same cycle as the success pulse.
- Default matching is overlapping: with pattern 0,1,0 (len 3), the stream 0,1,0,1,0 gives 2 hits.
- RUN → DONE on the cycle after the beat that:
  - makes hit_cnt == target (target≠0), or
  - makes sym_cnt == cfg_timeout (timeout≠0). This sets timeout=1.
- Hit and timeout on the same beat: hit wins, timeout=0; success still pulses.
- data_ready drops in the same cycle the DONE transition is registered. No beat is accepted after the terminating beat.
- abort in ARM/RUN → IDLE next cycle.
  - No success pulse is emitted for a beat accepted in that same cycle.
  - done=0; hit_cnt and sym_cnt are retained.
- abort has priority over start in the same cycle.
- DONE holds done (and timeout) until start (→ARM) or abort (→IDLE).
- cfg_we in the same cycle as start (from IDLE/DONE): the new config is loaded first and used by that run.
- Asynchronous reset mid-run: immediate return to reset values; no residual pulse.

Optional Feature:
- Macro: SEQ_DETECT_NON_OVERLAP_EN.
- Defined: on a hit, the fill count clears to 0, so the next match needs len fresh symbols. Stream 0,1,0,1,0 with pattern 0,1,0 gives 1 hit.
- Undefined: overlapping detection as specified above.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum (IDLE, ARM, RUN, DONE);
  - MAX_LEN, LEN_W, CNT_W, TMO_W defaults;
  - the len-clamp function.
- Sub-module seq_hist_window:
  - history shift register, fill counter and masked compare;
  - inputs: shift enable, clear, symbol, pattern, len;
  - output: registered-compatible match flag.
- The controller owns the FSM, counters and cfg shadow registers.

Test Plan:
- Config pattern 0,1,0 (len 3), target 0, timeout 0; start; stream 0,1,0,1,0 → success pulses after beats 3 and 5, hit_cnt=2, sym_cnt=5.
- Same stream with SEQ_DETECT_NON_OVERLAP_EN defined → single pulse after beat 3, hit_cnt=1.
- Target 2, pattern 3,3 (len 2); stream 3,3,3,x → done after beat 3, data_ready=0, 4th symbol not accepted, timeout=0.
- Timeout 4, pattern never present; 4 beats → done=1, timeout=1, sym_cnt=4; same stream with hit on beat 4 and target 1 → timeout=0.
- Abort asserted mid-run with data_valid on a would-be matching beat → IDLE, no success pulse, done=0; start with abort in the same cycle → stays IDLE.
- cfg_we during RUN → ignored; cfg_len=0 → behaves as len 1 (every symbol equal to pattern[1:0] hits); rst_n pulsed mid-run → all outputs 0 immediately.
